// File: rtl/ann_input_loader.sv
// Routes the host FIFO word stream into node memory, leaf memory and the query datapath.
// A load_kdtree pulse starts one fixed-length pass: node pairs, leaf records, then queries.
module ann_input_loader #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int LEAF_SIZE  = 8,
    parameter int NUM_LEAVES = 64,
    parameter int NUM_QUERYS = 512,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load_kdtree,
    input  logic                             in_fifo_rempty_n,
    input  logic [DATA_WIDTH-1:0]            in_fifo_rdata,
    output logic                             in_fifo_deq,
    output logic                             node_wen,
    output logic [ADDR_WIDTH-1:0]            node_waddr,
    output logic [2*DATA_WIDTH-1:0]          node_wdata,
    output logic                             leaf_wen,
    output logic [ADDR_WIDTH-1:0]            leaf_waddr,
    output logic [$clog2(LEAF_SIZE)-1:0]     leaf_wpatch,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] leaf_wdata,
    output logic [DATA_WIDTH-1:0]            leaf_widx,
    output logic                             query_valid,
    input  logic                             query_ready,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] query_patch,
    output logic [$clog2(NUM_QUERYS)-1:0]    query_addr,
    output logic                             load_done,
    output logic                             query_done,
    output logic                             busy
);
    localparam int NUM_NODES = NUM_LEAVES - 1;
    localparam int PW        = $clog2(LEAF_SIZE);
    localparam int QW        = $clog2(NUM_QUERYS);
    localparam int QCW       = QW + 1;
    localparam int PDW       = PATCH_SIZE * DATA_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] NODE_LAST  = ADDR_WIDTH'(NUM_NODES - 1);
    localparam logic [ADDR_WIDTH-1:0] LEAF_LAST  = ADDR_WIDTH'(NUM_LEAVES - 1);
    localparam logic [PW-1:0]         PATCH_LAST = PW'(LEAF_SIZE - 1);
    localparam logic [QW-1:0]         QUERY_LAST = QW'(NUM_QUERYS - 1);
    localparam logic [QCW-1:0]        QUERY_ALL  = QCW'(NUM_QUERYS);
    localparam logic [2:0]            WC_PLAST   = 3'(PATCH_SIZE - 1);
    localparam logic [2:0]            WC_IDX     = 3'(PATCH_SIZE);

    typedef enum logic [1:0] {IDLE, NODE, LEAF, QUERY} state_t;

    state_t                state;
    logic [2:0]            wc;
    logic [PDW-1:0]        acc;
    logic [ADDR_WIDTH-1:0] node_cnt;
    logic [ADDR_WIDTH-1:0] leaf_idx;
    logic [PW-1:0]         patch_idx;
    logic [QCW-1:0]        q_cnt;
    logic                  q_all;

    // Once every query is loaded the stream is complete; words after it are left in the FIFO.
    assign q_all = (q_cnt == QUERY_ALL);
    assign busy  = (state != IDLE);

    always_comb begin
        in_fifo_deq = 1'b0;
        case (state)
            NODE, LEAF: in_fifo_deq = in_fifo_rempty_n;
            QUERY:      in_fifo_deq = in_fifo_rempty_n & ~q_all & (~query_valid | query_ready);
            default:    in_fifo_deq = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wc          <= '0;
            acc         <= '0;
            node_cnt    <= '0;
            leaf_idx    <= '0;
            patch_idx   <= '0;
            q_cnt       <= '0;
            node_wen    <= 1'b0;
            node_waddr  <= '0;
            node_wdata  <= '0;
            leaf_wen    <= 1'b0;
            leaf_waddr  <= '0;
            leaf_wpatch <= '0;
            leaf_wdata  <= '0;
            leaf_widx   <= '0;
            query_valid <= 1'b0;
            query_patch <= '0;
            query_addr  <= '0;
            load_done   <= 1'b0;
            query_done  <= 1'b0;
        end else begin
            node_wen   <= 1'b0;
            leaf_wen   <= 1'b0;
            load_done  <= 1'b0;
            query_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_kdtree) begin
                        state       <= NODE;
                        wc          <= '0;
                        acc         <= '0;
                        node_cnt    <= '0;
                        leaf_idx    <= '0;
                        patch_idx   <= '0;
                        q_cnt       <= '0;
                        node_waddr  <= '0;
                        leaf_waddr  <= '0;
                        leaf_wpatch <= '0;
                        query_addr  <= '0;
                    end
                end
                NODE: begin
                    if (in_fifo_deq) begin
                        if (wc == 3'd1) begin
                            wc         <= '0;
                            node_wen   <= 1'b1;
                            node_waddr <= node_cnt;
                            node_wdata <= {in_fifo_rdata, acc[DATA_WIDTH-1:0]};
                            node_cnt   <= node_cnt + 1'b1;
                            if (node_cnt == NODE_LAST) state <= LEAF;
                        end else begin
                            acc[DATA_WIDTH-1:0] <= in_fifo_rdata;
                            wc                  <= wc + 3'd1;
                        end
                    end
                end
                LEAF: begin
                    if (in_fifo_deq) begin
                        if (wc == WC_IDX) begin
                            wc          <= '0;
                            leaf_wen    <= 1'b1;
                            leaf_waddr  <= leaf_idx;
                            leaf_wpatch <= patch_idx;
                            leaf_wdata  <= acc;
                            leaf_widx   <= in_fifo_rdata;
                            if (patch_idx == PATCH_LAST) begin
                                patch_idx <= '0;
                                leaf_idx  <= leaf_idx + 1'b1;
                                if (leaf_idx == LEAF_LAST) begin
                                    state     <= QUERY;
                                    load_done <= 1'b1;
                                end
                            end else begin
                                patch_idx <= patch_idx + 1'b1;
                            end
                        end else begin
                            acc[wc*DATA_WIDTH +: DATA_WIDTH] <= in_fifo_rdata;
                            wc                               <= wc + 3'd1;
                        end
                    end
                end
                QUERY: begin
                    if (query_valid && query_ready) begin
                        query_valid <= 1'b0;
                        if (query_addr == QUERY_LAST) begin
                            state      <= IDLE;
                            query_done <= 1'b1;
                        end
                    end
                    // A fifth word landing on a handshake edge reloads the register with no bubble.
                    if (in_fifo_deq) begin
                        if (wc == WC_PLAST) begin
                            wc          <= '0;
                            query_valid <= 1'b1;
                            query_patch <= {in_fifo_rdata, acc[(PATCH_SIZE-1)*DATA_WIDTH-1:0]};
                            query_addr  <= q_cnt[QW-1:0];
                            q_cnt       <= q_cnt + 1'b1;
                        end else begin
                            acc[wc*DATA_WIDTH +: DATA_WIDTH] <= in_fifo_rdata;
                            wc                               <= wc + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
